asps_gate_arbiter: RTL
======================

ASPS_GATE_ARBITER -- requirements
Module: asps_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 3, garage slot count; range 1..3.
REQ-002 Parameter TIMEOUT_TICKS, default 20, ticks an open gate waits for a car to pass.
REQ-003 Parameter GUARD_TICKS, default 4, ticks the gate stays closed before the next grant.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  one-clk strobe, 250 ms time base.
REQ-007 entry_req  input  1  debounced entry sensor, level.
REQ-008 exit_req  input  1  debounced exit sensor, level.
REQ-009 gate_pass  input  1  one-clk pulse: car has cleared the barrier.
REQ-010 gate_open  output  1  barrier open command.
REQ-011 grant_entry / grant_exit  output  1 each  direction currently being served.
REQ-012 occupancy  output  2  cars in garage.
REQ-013 full / empty  output  1 each  occupancy==CAPACITY / occupancy==0.
REQ-014 entry_done / exit_done / timeout_err / exit_refused  output  1 each  one-clk pulses.

Function
REQ-015 States: IDLE, OPEN_ENTRY, OPEN_EXIT, GUARD; encoding is free.
REQ-016 Rising edges of entry_req and exit_req are detected internally and set pending flags entry_pend and exit_pend; a flag stays set until its request is granted.
REQ-017 A rising edge arriving while its pending flag is already set is absorbed, with no second request queued.
REQ-018 A rising edge of exit_req while empty=1 and not in OPEN_EXIT sets no flag and produces an exit_refused pulse in the next clk.
REQ-019 IDLE: entry is eligible when entry_pend=1 and full=0; exit is eligible when exit_pend=1 and empty=0.
REQ-020 IDLE, both eligible: grant the direction opposite to last_grant (reset value: entry, so exit wins the first tie); one eligible: grant it; none: stay.
REQ-021 On a grant, the FSM moves to OPEN_x on the next clk, clears that pending flag, updates last_grant, and clears the tick counter.
REQ-022 gate_open=1 and the matching grant_x=1 exactly while in OPEN_ENTRY or OPEN_EXIT.
REQ-023 OPEN_x with gate_pass=1 in the same clk: occupancy ±1 (+ entry, − exit), x_done pulses 1 clk, and the FSM moves to GUARD.
REQ-024 OPEN_x, no gate_pass: the tick counter increments on each tick; when the counter reaches TIMEOUT_TICKS, timeout_err pulses 1 clk, occupancy is unchanged, and the FSM moves to GUARD.
REQ-025 gate_pass and the TIMEOUT_TICKS-th tick in the same clk: pass wins and timeout_err is not asserted.
REQ-026 gate_pass in IDLE or GUARD is ignored.
REQ-027 GUARD: gate_open=0; the counter restarts and counts ticks; after GUARD_TICKS ticks the FSM returns to IDLE.
REQ-028 Requests arriving in OPEN or GUARD are latched per REQ-016 and served after return to IDLE.
REQ-029 occupancy saturates: it never exceeds CAPACITY and never goes below 0; full and empty are combinational from occupancy.
REQ-030 An entry pending while full=1 stays pending and is granted once an exit brings occupancy below CAPACITY.

Reset
REQ-031 reset_n=0 forces IDLE asynchronously and clears occupancy, both pending flags, the counter, the edge-detect registers, and last_grant (=entry).
REQ-032 While reset_n=0: gate_open=0, grants=0, all pulses=0, empty=1, full=0.
REQ-033 Reset asserted mid-OPEN closes the gate immediately with no done/timeout pulse.
REQ-034 Outputs are valid from the first clk after reset_n deasserts.

Verification
REQ-035 Bench scenarios:
- Entry rise, gate_pass 3 ticks later -> gate_open high for the OPEN period, entry_done pulse, occupancy 0->1, GUARD lasts 4 ticks, then IDLE.
- Three entries served -> full=1; a fourth entry stays pending; an exit then completes -> occupancy 2, and the pending entry is granted after GUARD.
- Entry and exit rise in the same clk with occupancy=1 and last_grant=entry -> exit granted first, entry granted after GUARD; occupancy ends at 1.
- OPEN_ENTRY with no gate_pass -> timeout_err on the 20th tick, occupancy unchanged, gate closes.
- Exit rise at occupancy=0 -> exit_refused pulse, no gate_open, FSM stays in IDLE.
- reset_n low during OPEN_EXIT at occupancy=2 -> gate_open=0 and occupancy=0 immediately, no exit_done pulse.

Source files
------------

// File: rtl/asps_gate_arbiter.sv
// Parking-garage barrier arbiter: latches entry/exit requests, serves one direction
// at a time through a single gate, tracks occupancy and enforces pass timeout and guard time.
module asps_gate_arbiter #(
    parameter int CAPACITY      = 3,
    parameter int TIMEOUT_TICKS = 20,
    parameter int GUARD_TICKS   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       gate_pass,
    output logic       gate_open,
    output logic       grant_entry,
    output logic       grant_exit,
    output logic [1:0] occupancy,
    output logic       full,
    output logic       empty,
    output logic       entry_done,
    output logic       exit_done,
    output logic       timeout_err,
    output logic       exit_refused
);

    localparam int MAX_T = (TIMEOUT_TICKS > GUARD_TICKS) ? TIMEOUT_TICKS : GUARD_TICKS;
    localparam int CNT_W = $clog2(MAX_T + 1);
    localparam logic [1:0]       CAP      = 2'(CAPACITY);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_TICKS - 1);

    typedef enum logic [1:0] {IDLE, OPEN_ENTRY, OPEN_EXIT, GUARD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             entry_q, exit_q;
    logic             entry_pend, exit_pend;
    logic             last_grant;   // 0 = entry, 1 = exit

    logic entry_rise, exit_rise, exit_refuse;
    logic entry_ok, exit_ok, pick_entry, pick_exit;

    function automatic logic [1:0] occ_inc(input logic [1:0] o);
        return (o >= CAP) ? CAP : o + 2'd1;
    endfunction

    function automatic logic [1:0] occ_dec(input logic [1:0] o);
        return (o == 2'd0) ? 2'd0 : o - 2'd1;
    endfunction

    assign full  = (occupancy == CAP);
    assign empty = (occupancy == 2'd0);

    assign entry_rise  = entry_req & ~entry_q;
    assign exit_rise   = exit_req & ~exit_q;
    // Exit requests with nobody inside are rejected outright rather than queued
    assign exit_refuse = exit_rise & empty & (state != OPEN_EXIT);

    assign entry_ok   = entry_pend & ~full;
    assign exit_ok    = exit_pend & ~empty;
    assign pick_exit  = (state == IDLE) & exit_ok & (~entry_ok | ~last_grant);
    assign pick_entry = (state == IDLE) & entry_ok & ~pick_exit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            entry_q      <= 1'b0;
            exit_q       <= 1'b0;
            entry_pend   <= 1'b0;
            exit_pend    <= 1'b0;
            last_grant   <= 1'b0;
            occupancy    <= 2'd0;
            gate_open    <= 1'b0;
            grant_entry  <= 1'b0;
            grant_exit   <= 1'b0;
            entry_done   <= 1'b0;
            exit_done    <= 1'b0;
            timeout_err  <= 1'b0;
            exit_refused <= 1'b0;
        end else begin
            entry_q      <= entry_req;
            exit_q       <= exit_req;
            entry_done   <= 1'b0;
            exit_done    <= 1'b0;
            timeout_err  <= 1'b0;
            exit_refused <= exit_refuse;
            entry_pend   <= (entry_pend & ~pick_entry) | entry_rise;
            exit_pend    <= (exit_pend & ~pick_exit) | (exit_rise & ~exit_refuse);

            case (state)
                IDLE: begin
                    if (pick_exit) begin
                        state      <= OPEN_EXIT;
                        gate_open  <= 1'b1;
                        grant_exit <= 1'b1;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                    end else if (pick_entry) begin
                        state       <= OPEN_ENTRY;
                        gate_open   <= 1'b1;
                        grant_entry <= 1'b1;
                        last_grant  <= 1'b0;
                        cnt         <= '0;
                    end
                end
                OPEN_ENTRY, OPEN_EXIT: begin
                    // A pass in the same clk as the final tick takes priority over timeout
                    if (gate_pass || (tick && cnt == TMO_LAST)) begin
                        if (gate_pass) begin
                            if (state == OPEN_ENTRY) begin
                                occupancy  <= occ_inc(occupancy);
                                entry_done <= 1'b1;
                            end else begin
                                occupancy <= occ_dec(occupancy);
                                exit_done <= 1'b1;
                            end
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        state       <= GUARD;
                        gate_open   <= 1'b0;
                        grant_entry <= 1'b0;
                        grant_exit  <= 1'b0;
                        cnt         <= '0;
                    end else if (tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (tick) begin
                        if (cnt == GRD_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
